// File: rtl/alu_arbiter.sv
// Round-robin controller that time-shares one small combinational ALU between two clients.
// Operands are registered onto the ALU, held for ALU_LAT cycles, then the result is captured.
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [1:0] op0,
    input  logic [2:0] a0,
    input  logic [2:0] b0,
    input  logic       req1,
    input  logic [1:0] op1,
    input  logic [2:0] a1,
    input  logic [2:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [3:0] result,
    output logic       busy,
    output logic [1:0] alu_sel,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    input  logic [3:0] alu_q
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] LAT = 4'(ALU_LAT);

    logic [1:0] state;
    logic [3:0] settle_cnt;
    logic       owner;
    logic       prio;
    logic       pick1;

    // prio high means client 1 wins a tie
    always_comb begin
        pick1 = req1 && (!req0 || prio);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
            owner      <= 1'b0;
            prio       <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            result     <= 4'h0;
            alu_sel    <= 2'b00;
            alu_a      <= 3'b000;
            alu_b      <= 3'b000;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner      <= pick1;
                        alu_sel    <= pick1 ? op1 : op0;
                        alu_a      <= pick1 ? a1 : a0;
                        alu_b      <= pick1 ? b1 : b0;
                        settle_cnt <= LAT;
                        gnt0       <= !pick1;
                        gnt1       <= pick1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt == 4'd1) begin
                        result <= alu_q;
                        done0  <= !owner;
                        done1  <= owner;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    prio  <= !owner;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
